// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1, PC-2 and shift tables (FIPS 1-based bit numbers),
// the C/D register type, the sequencer states and the per-half rotation helpers.
package des_pkg;

    localparam int DES_ROUNDS = 16;
    localparam logic [3:0] LAST_ROUND = 4'(DES_ROUNDS - 1);

    typedef logic [55:0] des_cd_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } ks_state_e;

    localparam int PC1 [56] = '{
        57, 49, 41, 33, 25, 17,  9,
         1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27,
        19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,
         7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29,
        21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2 [48] = '{
        14, 17, 11, 24,  1,  5,
         3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8,
        16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55,
        30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53,
        46, 42, 50, 36, 29, 32
    };

    localparam logic [1:0] SHIFT [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    // C occupies cd[55:28] and D cd[27:0]; each half rotates on its own by 1 or 2.
    function automatic des_cd_t rotl_cd(input des_cd_t cd, input logic [1:0] amt);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        if (amt == 2'd2) begin
            c = {c[25:0], c[27:26]};
            d = {d[25:0], d[27:26]};
        end else begin
            c = {c[26:0], c[27]};
            d = {d[26:0], d[27]};
        end
        return {c, d};
    endfunction

    function automatic des_cd_t rotr_cd(input des_cd_t cd, input logic [1:0] amt);
        logic [27:0] c;
        logic [27:0] d;
        c = cd[55:28];
        d = cd[27:0];
        if (amt == 2'd2) begin
            c = {c[1:0], c[27:2]};
            d = {d[1:0], d[27:2]};
        end else begin
            c = {c[0], c[27:1]};
            d = {d[0], d[27:1]};
        end
        return {c, d};
    endfunction

endpackage

// File: rtl/des_pc2.sv
// PC-2 compression: pure bit selection from the 56-bit C/D pair to a 48-bit round key.
module des_pc2
    import des_pkg::*;
(
    input  des_cd_t     cd_i,
    output logic [47:0] rkey_o
);

    for (genvar g = 0; g < 48; g++) begin : g_sel
        assign rkey_o[47 - g] = cd_i[56 - PC2[g]];
    end

    // FIPS C/D bits 9, 18, 22, 25, 35, 38, 43 and 54 are dropped by PC-2.
    logic unused_cd;
    assign unused_cd = ^{cd_i[47], cd_i[38], cd_i[34], cd_i[31],
                         cd_i[21], cd_i[18], cd_i[13], cd_i[2]};

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES round-key generator: accepts one key, then streams 16 round keys in
// encrypt (K1..K16) or decrypt (K16..K1) order using rotations only.
module des_key_schedule
    import des_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        key_valid_i,
    output logic        key_ready_o,
    input  logic [63:0] key_i,
    input  logic        decrypt_i,
    input  logic        abort_i,
    output logic        rkey_valid_o,
    input  logic        rkey_ready_i,
    output logic [47:0] rkey_o,
    output logic [3:0]  round_o,
    output logic        last_o
);

    ks_state_e   state_q, state_d;
    des_cd_t     cd_q, cd_d;
    logic [3:0]  round_q, round_d;
    logic        dec_q, dec_d;
    des_cd_t     pc1_key;

    for (genvar g = 0; g < 56; g++) begin : g_pc1
        assign pc1_key[55 - g] = key_i[64 - PC1[g]];
    end

    // Parity bits (FIPS 8, 16, ..., 64) never reach the schedule.
    logic unused_parity;
    assign unused_parity = ^{key_i[56], key_i[48], key_i[40], key_i[32],
                             key_i[24], key_i[16], key_i[8],  key_i[0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cd_q    <= '0;
            round_q <= '0;
            dec_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cd_q    <= cd_d;
            round_q <= round_d;
            dec_q   <= dec_d;
        end
    end

    // Decrypt starts from the unrotated C0/D0: the full 28-bit cycle makes that K16.
    always_comb begin
        state_d = state_q;
        cd_d    = cd_q;
        round_d = round_q;
        dec_d   = dec_q;
        unique case (state_q)
            ST_IDLE: begin
                if (key_valid_i) begin
                    cd_d    = decrypt_i ? pc1_key : rotl_cd(pc1_key, 2'd1);
                    dec_d   = decrypt_i;
                    round_d = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rkey_ready_i) begin
                    if (round_q == LAST_ROUND) begin
                        state_d = ST_IDLE;
                        round_d = '0;
                    end else begin
                        round_d = round_q + 4'd1;
                        cd_d    = dec_q ? rotr_cd(cd_q, SHIFT[4'd15 - round_q])
                                        : rotl_cd(cd_q, SHIFT[round_q + 4'd1]);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) begin
            state_d = ST_IDLE;
            round_d = '0;
        end
    end

    des_pc2 u_pc2 (
        .cd_i   (cd_q),
        .rkey_o (rkey_o)
    );

    assign key_ready_o  = (state_q == ST_IDLE);
    assign rkey_valid_o = (state_q == ST_RUN);
    assign round_o      = round_q;
    assign last_o       = (state_q == ST_RUN) && (round_q == LAST_ROUND);

endmodule
